// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the 2-phase register bus initiator.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } bus_state_e;

  localparam int          TMO_CYC_DEFAULT = 255;
  localparam logic [31:0] ERR_RDATA       = 32'h0000_0000;

endpackage

// File: rtl/reg_bus_initiator.sv
// Register bus initiator: one bus transaction per accepted command, with an
// ack timeout so a missing responder cannot hang the host.
module reg_bus_initiator
  import reg_bus_pkg::*;
#(
  parameter int AW      = 2,
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
  input  logic          mclk,
  input  logic          h_reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [31:0]   cmd_wdata,
  input  logic [3:0]    cmd_be,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          reg_cs,
  output logic          reg_wr,
  output logic [AW-1:0] reg_addr,
  output logic [31:0]   reg_wdata,
  output logic [3:0]    reg_be,
  input  logic [31:0]   reg_rdata,
  input  logic          reg_ack,
  output logic          busy
);

  // Handshakes: a command moves when cmd_valid & cmd_ready are both high at a
  // rising mclk edge; a response moves when rsp_valid & rsp_ready are both
  // high. Valid never drops before its transfer.

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  bus_state_e       state, state_d;
  logic [TMO_W-1:0] tmo_cnt, tmo_d;
  logic             load_cmd;
  logic             tmo_hit;
  logic [31:0]      rsp_rdata_d;
  logic             rsp_err_d;

  assign tmo_hit = (TMO_CYC != 0) && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_d     = state;
    tmo_d       = tmo_cnt;
    load_cmd    = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          load_cmd = 1'b1;
          tmo_d    = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (reg_ack) begin
          rsp_rdata_d = reg_wr ? ERR_RDATA : reg_rdata;
          rsp_err_d   = 1'b0;
          state_d     = RSP;
        end else if (tmo_hit) begin
          rsp_rdata_d = ERR_RDATA;
          rsp_err_d   = 1'b1;
          state_d     = RSP;
        end else begin
          tmo_d = tmo_cnt + 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs are registered from the next state; leaving REQ always passes
  // through RSP and IDLE, which keeps reg_cs low for at least two cycles.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      reg_cs    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_be    <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      tmo_cnt   <= tmo_d;
      cmd_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RSP);
      reg_cs    <= (state_d == REQ);
      busy      <= (state_d != IDLE);
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      if (load_cmd) begin
        reg_wr    <= cmd_wr;
        reg_addr  <= cmd_addr;
        reg_wdata <= cmd_wdata;
        reg_be    <= cmd_be;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Bench for reg_bus_initiator: behavioural responder, per-cycle timeline model,
// directed scenarios and a randomized phase.
module tb_reg_bus_initiator;

  localparam int AW  = 2;
  localparam int TMO = 8;

  logic          mclk = 1'b0;
  logic          h_reset_n = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_be;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          reg_cs, reg_wr;
  logic [AW-1:0] reg_addr;
  logic [31:0]   reg_wdata, reg_rdata;
  logic [3:0]    reg_be;
  logic          reg_ack, busy;

  reg_bus_initiator #(.AW(AW), .TMO_W(8), .TMO_CYC(TMO)) dut (
    .mclk(mclk), .h_reset_n(h_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack), .busy(busy)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 mclk = ~mclk;
  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired t=%0t", name, $time);
  endtask

  // ---------------- responder (peripheral) ----------------
  logic [31:0] rmem [4];
  logic [31:0] mmem [4];
  bit          resp_en = 1'b1;
  int          resp_lat = 1;
  bit          inject_ack = 1'b0;
  int          resp_writes = 0;
  int          r_cnt;
  bit          p_valid, p_wr;
  logic [1:0]  p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  p_be;

  initial begin
    reg_ack = 1'b0; reg_rdata = '0; r_cnt = 0; p_valid = 1'b0;
    forever begin
      @(posedge mclk); #1;
      if (!h_reset_n) begin
        reg_ack = 1'b0; reg_rdata = '0; r_cnt = 0; p_valid = 1'b0;
      end else if (reg_ack) begin
        if (p_valid && p_wr) begin
          for (int b = 0; b < 4; b++)
            if (p_be[b]) rmem[p_addr][8*b +: 8] = p_wdata[8*b +: 8];
          resp_writes++;
        end
        reg_ack = 1'b0; reg_rdata = '0; r_cnt = 0; p_valid = 1'b0;
      end else if (inject_ack) begin
        reg_ack = 1'b1; reg_rdata = 32'hDEAD_BEEF; inject_ack = 1'b0; p_valid = 1'b0;
      end else if (resp_en && reg_cs) begin
        if (r_cnt >= resp_lat) begin
          reg_ack = 1'b1; p_valid = 1'b1; p_wr = reg_wr; p_addr = reg_addr;
          p_wdata = reg_wdata; p_be = reg_be;
          reg_rdata = reg_wr ? 32'hFFFF_FFFF : rmem[reg_addr];
        end else begin
          r_cnt++;
        end
      end else begin
        r_cnt = 0;
      end
    end
  end

  // ---------------- response-ready policy ----------------
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge mclk); #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  // Each accepted command yields a timeline: cs high for cycles 1..L after the
  // accept cycle, response valid from cycle L+1 until consumed.
  bit          active = 1'b0;
  int          since = 0;
  int          acc_cyc, exp_len;
  logic        m_wr;
  logic [1:0]  m_addr;
  logic [31:0] m_wdata, e_rdata;
  logic [3:0]  m_be;
  logic        e_err;
  int          exp_writes = 0;
  int          cs_run = 0, cs_gap = 100, last_cs_len = 0;
  bit          seen_cs = 1'b0;

  always @(negedge mclk) begin
    if (!h_reset_n) begin
      chk("rst_reg_cs", 32'(reg_cs), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      active = 1'b0; since = 0; cs_run = 0; cs_gap = 100;
    end else begin : mon
      int t;
      bit exp_cs, exp_rv;
      t = cyc - acc_cyc;
      exp_cs = active && (t <= exp_len);
      exp_rv = active && (t > exp_len);
      chk("reg_cs", 32'(reg_cs), 32'(exp_cs));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("busy", 32'(busy), 32'(active));
      chk("cmd_ready", 32'(cmd_ready), 32'(!active && since >= 1));
      if (exp_cs) begin
        chk("reg_wr", 32'(reg_wr), 32'(m_wr));
        chk("reg_addr", 32'(reg_addr), 32'(m_addr));
        chk("reg_wdata", reg_wdata, m_wdata);
        chk("reg_be", 32'(reg_be), 32'(m_be));
      end
      if (exp_rv) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
      end
      if (reg_cs) begin
        if (cs_run == 0 && seen_cs) chk("cs_gap_ge2", 32'(cs_gap >= 2), 32'd1);
        cs_run++; cs_gap = 0; seen_cs = 1'b1;
      end else begin
        if (cs_run != 0) last_cs_len = cs_run;
        cs_run = 0; cs_gap++;
      end
      if (exp_rv && rsp_ready) begin
        active = 1'b0;
      end else if (!active && since >= 1 && cmd_valid) begin
        m_wr = cmd_wr; m_addr = cmd_addr; m_wdata = cmd_wdata; m_be = cmd_be;
        if (!resp_en || resp_lat + 1 > TMO) begin
          e_err = 1'b1; e_rdata = 32'h0; exp_len = TMO;
        end else begin
          e_err = 1'b0; exp_len = resp_lat + 1;
          e_rdata = cmd_wr ? 32'h0 : mmem[cmd_addr];
          if (cmd_wr) begin
            for (int b = 0; b < 4; b++)
              if (cmd_be[b]) mmem[cmd_addr][8*b +: 8] = cmd_wdata[8*b +: 8];
            exp_writes++;
          end
        end
        active = 1'b1; acc_cyc = cyc;
      end
      since++;
    end
  end

  // ---------------- driver tasks ----------------
  int issue_cyc = 0;

  task automatic issue(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    int n;
    @(posedge mclk); #1;
    cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be; cmd_valid = 1'b1;
    n = 0;
    @(negedge mclk);
    while (!cmd_ready && n < 200) begin
      @(negedge mclk);
      n++;
    end
    if (n >= 200) bound_fail("cmd_accept");
    issue_cyc = cyc;
    @(posedge mclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0; lat = -1;
    forever begin
      @(negedge mclk);
      if (rsp_valid && lat < 0) lat = cyc - issue_cyc;
      if (rsp_valid && rsp_ready) break;
      n++;
      if (n >= 300) begin
        bound_fail("rsp_handshake");
        break;
      end
    end
    rd = rsp_rdata; er = rsp_err;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge mclk);
    while (!rsp_valid && n < 300) begin
      @(negedge mclk);
      n++;
    end
    if (n >= 300) bound_fail("rsp_valid_rise");
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [31:0] rd, v0;
    logic        er;
    int          lat, wc0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
    for (int i = 0; i < 4; i++) begin
      rmem[i] = 32'h0; mmem[i] = 32'h0;
    end
    #1 h_reset_n = 1'b0;
    repeat (3) @(posedge mclk);
    #1 h_reset_n = 1'b1;
    repeat (2) @(posedge mclk);
    #1 chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

    // immediate responder write
    resp_en = 1'b1; resp_lat = 1; rdy_mode = 0;
    issue(1'b1, 2'd0, 32'h0000_0507, 4'b0001);
    wait_rsp(rd, er, lat);
    chk("wr_rsp_latency", 32'(lat), 32'd3);
    chk("wr_rsp_rdata", rd, 32'h0);
    chk("wr_rsp_err", 32'(er), 32'd0);
    @(posedge mclk); #1;
    chk("wr_cs_len", 32'(last_cs_len), 32'd2);
    chk("wr_committed", rmem[0], 32'h0000_0007);
    chk("wr_count_1", 32'(resp_writes), 32'd1);

    // read with wait states
    resp_lat = 0;
    issue(1'b1, 2'd2, 32'h0000_002A, 4'b1111);
    wait_rsp(rd, er, lat);
    resp_lat = 6;
    issue(1'b0, 2'd2, 32'h1234_5678, 4'b1111);
    wait_rsp(rd, er, lat);
    chk("rd_rdata", rd, 32'h0000_002A);
    chk("rd_err", 32'(er), 32'd0);
    chk("rd_latency", 32'(lat), 32'd8);
    @(posedge mclk); #1;
    chk("rd_cs_len", 32'(last_cs_len), 32'd7);

    // timeout, late ack in RSP and in IDLE
    resp_en = 1'b0; rdy_mode = 2;
    issue(1'b1, 2'd1, 32'hCAFE_F00D, 4'b1111);
    wait_valid();
    inject_ack = 1'b1;
    repeat (3) @(negedge mclk);
    rdy_mode = 0;
    wait_rsp(rd, er, lat);
    chk("tmo_err", 32'(er), 32'd1);
    chk("tmo_rdata", rd, 32'h0);
    @(posedge mclk); #1;
    chk("tmo_cs_len", 32'(last_cs_len), 32'd8);
    inject_ack = 1'b1;
    repeat (4) @(posedge mclk);
    #1;
    chk("late_ack_idle_busy", 32'(busy), 32'd0);
    chk("late_ack_idle_ready", 32'(cmd_ready), 32'd1);
    chk("late_ack_no_rsp", 32'(rsp_valid), 32'd0);
    chk("tmo_no_commit", rmem[1], 32'h0);

    // back-to-back writes with cmd_valid re-asserted immediately
    resp_en = 1'b1; resp_lat = 1; rdy_mode = 0;
    wc0 = resp_writes;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 2'(i), $urandom, 4'(i + 1));
      wait_rsp(rd, er, lat);
    end
    @(posedge mclk); #1;
    chk("b2b_write_count", 32'(resp_writes - wc0), 32'd6);

    // response back-pressure
    rdy_mode = 2; resp_lat = 2;
    issue(1'b0, 2'd3, 32'h0, 4'hF);
    wait_valid();
    v0 = rsp_rdata;
    for (int i = 0; i < 10; i++) begin
      @(negedge mclk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, v0);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_no_cs", 32'(reg_cs), 32'd0);
    end
    rdy_mode = 0;
    wait_rsp(rd, er, lat);

    // reset while in REQ
    resp_en = 1'b0;
    issue(1'b0, 2'd1, 32'h0, 4'hF);
    repeat (3) @(posedge mclk);
    #3 h_reset_n = 1'b0;
    #1;
    chk("async_rst_cs", 32'(reg_cs), 32'd0);
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge mclk);
    #1 h_reset_n = 1'b1;
    repeat (2) @(posedge mclk);
    #1;
    chk("after_rst_ready", 32'(cmd_ready), 32'd1);
    chk("after_rst_busy", 32'(busy), 32'd0);
    repeat (10) @(posedge mclk);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      resp_en  = ($urandom_range(0, 9) != 0);
      resp_lat = $urandom_range(0, 6);
      rdy_mode = $urandom_range(0, 1);
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15)));
      wait_rsp(rd, er, lat);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge mclk);
    end
    rdy_mode = 0;
    repeat (4) @(posedge mclk);
    #1;
    chk("final_write_count", 32'(resp_writes), 32'(exp_writes));
    for (int i = 0; i < 4; i++) chk("final_mem", rmem[i], mmem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
